// File: rtl/mf_disp_sync_pkg.sv
// Shared constants and helpers for the multi-channel async-level synchroniser.
package mf_disp_sync_pkg;
   localparam int MF_SYNC_MIN_STAGES = 2;

   // Filter counter width; never below 1 bit so the unfiltered build stays legal.
   function automatic int mf_filt_cnt_w(input int filt_cyc);
      return (filt_cyc < 1) ? 1 : $clog2(filt_cyc + 1);
   endfunction
endpackage

// File: rtl/mf_disp_sync_chan.sv
// One channel: sync chain, stability filter, registered rise/fall pulses.
// Optional sticky change flag under MF_DISP_SYNC_STICKY_EN.
module mf_disp_sync_chan
   import mf_disp_sync_pkg::*;
#(
   parameter int   STAGES   = 2,
   parameter int   FILT_CYC = 4,
   parameter logic RST_VAL  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic in_async,
   input  logic sticky_clr,
   output logic out_sync,
   output logic rise,
   output logic fall,
   output logic sticky
);
   localparam int CW = mf_filt_cnt_w(FILT_CYC);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              out_q, out_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              raw;

   assign raw = chain_q[STAGES-1];

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], in_async};
      cnt_d   = '0;
      out_d   = out_q;
      if (FILT_CYC <= 1) begin
         out_d = raw;
      end else if (raw == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(FILT_CYC - 1)) begin
         out_d = raw;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      // Pulses are derived from the next state so they line up with out_sync.
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain_q <= {STAGES{RST_VAL}};
         cnt_q   <= '0;
         out_q   <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         chain_q <= chain_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign out_sync = out_q;
   assign rise     = rise_q;
   assign fall     = fall_q;

`ifdef MF_DISP_SYNC_STICKY_EN
   logic sticky_q, sticky_d;

   // Set has priority over a coincident clear.
   always_comb begin
      sticky_d = sticky_q;
      if (sticky_clr) sticky_d = 1'b0;
      if (rise_d | fall_d) sticky_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sticky_q <= 1'b0;
      else       sticky_q <= sticky_d;
   end

   assign sticky = sticky_q;
`else
   logic unused_sticky_clr;
   assign unused_sticky_clr = sticky_clr;
   assign sticky = 1'b0;
`endif
endmodule

// File: rtl/mf_disp_sync_multi.sv
// WIDTH independent async-level synchronisers with glitch filter and edge pulses.
// Define MF_DISP_SYNC_STICKY_EN to add per-channel sticky change flags.
module mf_disp_sync_multi
   import mf_disp_sync_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter int               STAGES   = 2,
   parameter int               FILT_CYC = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_async,
   output logic [WIDTH-1:0] out_sync,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   input  logic [WIDTH-1:0] sticky_clr,
   output logic [WIDTH-1:0] sticky
);
   if (STAGES < MF_SYNC_MIN_STAGES) begin : g_err_stages
      $error("mf_disp_sync_multi: STAGES must be >= %0d", MF_SYNC_MIN_STAGES);
   end
   if (WIDTH < 1) begin : g_err_width
      $error("mf_disp_sync_multi: WIDTH must be >= 1");
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      mf_disp_sync_chan #(
         .STAGES   (STAGES),
         .FILT_CYC (FILT_CYC),
         .RST_VAL  (RST_VAL[g])
      ) u_chan (
         .clk        (clk),
         .reset      (reset),
         .in_async   (in_async[g]),
         .sticky_clr (sticky_clr[g]),
         .out_sync   (out_sync[g]),
         .rise       (rise[g]),
         .fall       (fall[g]),
         .sticky     (sticky[g])
      );
   end
endmodule

// File: tb/tb_mf_disp_sync_multi.sv
// Scoreboarded directed bench: default DUT plus a STAGES=3/FILT_CYC=0/RST_VAL=F variant.
module tb_mf_disp_sync_multi;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_a, clr_a, in_b, clr_b;
   logic [3:0] out_a, rise_a, fall_a, sticky_a;
   logic [3:0] out_b, rise_b, fall_b, sticky_b;

   typedef struct {
      int cyc;
      int dut;
      int ch;
      bit is_rise;
   } ev_t;

   ev_t        q[$];
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic [3:0] exp_out[2];
   logic [3:0] exp_sticky;
   logic [3:0] clr_smp;
   logic [3:0] er[2], ef[2];

   mf_disp_sync_multi u_dut_a (
      .clk(clk), .reset(reset), .in_async(in_a), .out_sync(out_a),
      .rise(rise_a), .fall(fall_a), .sticky_clr(clr_a), .sticky(sticky_a)
   );

   mf_disp_sync_multi #(.WIDTH(4), .STAGES(3), .FILT_CYC(0), .RST_VAL(4'hF)) u_dut_b (
      .clk(clk), .reset(reset), .in_async(in_b), .out_sync(out_b),
      .rise(rise_b), .fall(fall_b), .sticky_clr(clr_b), .sticky(sticky_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      clr_smp <= clr_a;
   end

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int d, input int lat, input int ch, input bit r);
      q.push_back('{cyc: cyc + lat, dut: d, ch: ch, is_rise: r});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      exp_out[0] = 4'h0;
      exp_out[1] = 4'hF;
      exp_sticky = 4'h0;
   endtask

   // Pop events due this cycle, advance the model, compare every output.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         er[d] = 4'h0;
         ef[d] = 4'h0;
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc == cyc) begin
            if (q[i].is_rise) er[q[i].dut][q[i].ch] = 1'b1;
            else              ef[q[i].dut][q[i].ch] = 1'b1;
            q.delete(i);
         end
      end
      for (int d = 0; d < 2; d++) exp_out[d] = (exp_out[d] | er[d]) & ~ef[d];
`ifdef MF_DISP_SYNC_STICKY_EN
      if (reset) exp_sticky = 4'h0;
      else       exp_sticky = (exp_sticky & ~clr_smp) | er[0] | ef[0];
`else
      exp_sticky = 4'h0;
`endif
      chk("a_out",    out_a,    exp_out[0]);
      chk("a_rise",   rise_a,   er[0]);
      chk("a_fall",   fall_a,   ef[0]);
      chk("a_sticky", sticky_a, exp_sticky);
      chk("b_out",    out_b,    exp_out[1]);
      chk("b_rise",   rise_b,   er[1]);
      chk("b_fall",   fall_b,   ef[1]);
      chk("b_sticky", sticky_b, 4'h0);
   end

   initial begin
      reset = 1'b1;
      in_a  = 4'h0;
      clr_a = 4'h0;
      in_b  = 4'hF;
      clr_b = 4'h0;
      model_reset();
      step(3);
      reset = 1'b0;

      // Idle after reset: no activity at all.
      step(20);

      // Clean rise then fall on channel 0.
      in_a[0] = 1'b1; push(0, 6, 0, 1'b1);
      step(10);
      in_a[0] = 1'b0; push(0, 6, 0, 1'b0);
      step(10);

      // 3-cycle glitch is filtered; 4-cycle pulse is accepted.
      in_a[1] = 1'b1;
      step(3);
      in_a[1] = 1'b0;
      step(10);
      in_a[1] = 1'b1; push(0, 6, 1, 1'b1);
      step(4);
      in_a[1] = 1'b0; push(0, 6, 1, 1'b0);
      step(12);

      // Rise on channel 3 coinciding with sticky_clr, then a real clear.
      in_a[3] = 1'b1; push(0, 6, 3, 1'b1);
      step(5);
      clr_a[3] = 1'b1;
      step(1);
      step(1);
      clr_a[3] = 1'b0;
      step(3);

      // Async reset while channel 2 is mid-qualification.
      in_a[2] = 1'b1;
      step(4);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk("async_rst_out",  out_a,  4'h0);
      chk("async_rst_rise", rise_a, 4'h0);
      chk("async_rst_fall", fall_a, 4'h0);
      chk("async_rst_outb", out_b,  4'hF);
      step(2);
      reset = 1'b0;
      push(0, 6, 2, 1'b1);
      push(0, 6, 3, 1'b1);
      step(10);

      // Unfiltered 3-stage variant with all-ones reset level.
      in_b[0] = 1'b0; push(1, 4, 0, 1'b0);
      step(8);

      chk("queue_drained", 4'(q.size()), 4'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
